bcd_to_bin: RTL and testbench

Sequential BCD-to-binary converter: the inverse of the team's binary-to-BCD block. It accepts a packed 4-digit BCD value and produces its 14-bit unsigned binary equivalent using iterative reverse double-dabble (shift right, then subtract 3 from each digit ≥ 8). It sits between decimal front-ends (keypad entry, 7-segment editors) and binary datapaths, using the same start/done handshake as its forward counterpart.

---
 rtl/bcd_to_bin.sv | 114 +++++++++++
 tb/tb_bcd_to_bin.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// Sequential 4-digit BCD to 14-bit binary converter using reverse double-dabble.
// One conversion per start_op: W shift iterations, then a single-cycle done pulse.
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int W      = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_op,
  input  logic [4*DIGITS-1:0]   in_BCD,
  output logic [W-1:0]          bin,
  output logic                  done,
  output logic                  err,
  output logic                  busy
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   bcd_sr_q, bcd_sr_d;
  logic [W-1:0]    bin_sr_q, bin_sr_d;
  logic [W-1:0]    bin_q, bin_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [BW+W-1:0] shifted;
  logic [3:0]      nib;
  logic            bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (in_BCD[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // One reverse double-dabble step: shift right, then pull each digit >= 8 back by 3.
  always_comb begin
    nib     = '0;
    shifted = {bcd_sr_q, bin_sr_q} >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      nib = shifted[W+4*i +: 4];
      if (nib >= 4'd8) shifted[W+4*i +: 4] = nib - 4'd3;
    end
  end

  always_comb begin
    state_d  = state_q;
    bcd_sr_d = bcd_sr_q;
    bin_sr_d = bin_sr_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start_op) begin
          if (bad_digit) begin
            err_d   = 1'b1;
            bin_d   = '0;
            state_d = DONE;
          end else begin
            bcd_sr_d = in_BCD;
            bin_sr_d = '0;
            err_d    = 1'b0;
            cnt_d    = CW'(W - 1);
            state_d  = OP;
          end
        end
      end
      OP: begin
        {bcd_sr_d, bin_sr_d} = shifted;
        if (cnt_q == '0) begin
          bin_d   = shifted[W-1:0];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bcd_sr_q <= '0;
      bin_sr_q <= '0;
      cnt_q    <= '0;
      bin_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcd_sr_q <= bcd_sr_d;
      bin_sr_q <= bin_sr_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      err_q    <= err_d;
    end
  end

  assign bin  = bin_q;
  assign err  = err_q;
  assign done = (state_q == DONE);
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_to_bin.sv
// Bench for bcd_to_bin: vector table, hand-written corner sequences and a random sweep,
// all results checked through an expected queue popped on every done pulse.
module tb_bcd_to_bin;

  localparam int DIGITS = 4;
  localparam int W      = 14;

  logic                clk;
  logic                rst;
  logic                start_op;
  logic [4*DIGITS-1:0] in_BCD;
  logic [W-1:0]        bin;
  logic                done;
  logic                err;
  logic                busy;

  bcd_to_bin #(.DIGITS(DIGITS), .W(W)) dut (
    .clk(clk), .rst(rst), .start_op(start_op), .in_BCD(in_BCD),
    .bin(bin), .done(done), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;
  logic [W:0] exp_q[$];
  int done_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W:0] ref_model(input logic [15:0] b);
    int v;
    v = 0;
    for (int i = 3; i >= 0; i--) begin
      if (b[4*i +: 4] > 4'd9) return {1'b1, {W{1'b0}}};
      v = v * 10 + int'(b[4*i +: 4]);
    end
    return {1'b0, W'(v)};
  endfunction

  // Scoreboard: every done pulse consumes one expected {err, bin}.
  always @(negedge clk) begin
    logic [W:0] e;
    if (done) begin
      done_cnt++;
      done_cyc_q.push_back(cyc);
      chk("done_not_consecutive", 32'(prev_done), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("bin", 32'(bin), 32'(e[W-1:0]));
        chk("err", 32'(err), 32'(e[W]));
        if (!e[W]) chk("residue", 32'(dut.bcd_sr_q), 32'd0);
      end
    end
    prev_done = done;
  end

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_conv(input string name, input logic [15:0] bcd,
                         input logic [W-1:0] exp_bin, input logic exp_err, input int exp_lat);
    int lat = 0;
    int busy_cnt = 0;
    logic got = 1'b0;
    wait_idle();
    start_op = 1'b1;
    in_BCD   = bcd;
    exp_q.push_back({exp_err, exp_bin});
    @(posedge clk);
    #1;
    start_op = 1'b0;
    in_BCD   = 16'($urandom);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (done) got = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(got), 32'd1);
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    @(negedge clk);
    chk({name, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [15:0]  bcd;
    logic [W-1:0] exp_bin;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int d0;
    int k;
    logic got;
    logic [15:0] b;
    logic [W:0] m;

    vecs[0] = '{16'h1234, 14'h04D2, 1'b0, 15};
    vecs[1] = '{16'h9999, 14'h270F, 1'b0, 15};
    vecs[2] = '{16'h0000, 14'h0000, 1'b0, 15};
    vecs[3] = '{16'h0001, 14'h0001, 1'b0, 15};
    vecs[4] = '{16'h12A4, 14'h0000, 1'b1, 1};
    vecs[5] = '{16'h0050, 14'd50,   1'b0, 15};

    // Reset with start_op asserted: reset must win.
    rst = 1'b1;
    start_op = 1'b1;
    in_BCD = 16'h1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_bin", 32'(bin), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    start_op = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      do_conv($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].exp_bin, vecs[i].exp_err, vecs[i].exp_lat);

    // start_op pulsed during OP and during DONE must be ignored.
    wait_idle();
    d0 = done_cnt;
    start_op = 1'b1;
    in_BCD = 16'h1234;
    exp_q.push_back({1'b0, 14'h04D2});
    @(posedge clk);
    #1;
    start_op = 1'b0;
    repeat (4) @(negedge clk);
    start_op = 1'b1;
    in_BCD = 16'h5555;
    @(negedge clk);
    start_op = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("ignore_done_seen", 32'(got), 32'd1);
    start_op = 1'b1;
    in_BCD = 16'h9999;
    @(negedge clk);
    start_op = 1'b0;
    chk("ignore_in_done_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    chk("ignore_done_count", 32'(done_cnt - d0), 32'd1);
    chk("ignore_bin_held", 32'(bin), 32'h04D2);

    // Reset in cycle 7 of a conversion aborts it silently.
    wait_idle();
    d0 = done_cnt;
    start_op = 1'b1;
    in_BCD = 16'h4321;
    @(posedge clk);
    #1;
    start_op = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_bin", 32'(bin), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    do_conv("after_abort", 16'h0808, 14'd808, 1'b0, 15);

    // start_op held high: three back-to-back conversions.
    wait_idle();
    done_cyc_q.delete();
    start_op = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b = (i == 0) ? 16'h0010 : (i == 1) ? 16'h0100 : 16'h1000;
      k = 0;
      while (busy && k < 40) begin
        @(negedge clk);
        k++;
      end
      if (busy) chk("b2b_idle_timeout", 32'(busy), 32'd0);
      in_BCD = b;
      exp_q.push_back(ref_model(b));
      @(negedge clk);
      if (i == 2) start_op = 1'b0;
    end
    k = 0;
    while (done_cyc_q.size() < 3 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_done_count", 32'(done_cyc_q.size()), 32'd3);
    if (done_cyc_q.size() == 3) begin
      chk("b2b_gap1", 32'(done_cyc_q[1] - done_cyc_q[0]), 32'd16);
      chk("b2b_gap2", 32'(done_cyc_q[2] - done_cyc_q[1]), 32'd16);
    end

    // Random sweep of valid inputs plus a few invalid ones.
    for (int n = 0; n < 300; n++) begin
      b = '0;
      for (int i = 0; i < 4; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
      if (n % 15 == 14) b[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      m = ref_model(b);
      do_conv("sweep", b, m[W-1:0], m[W], m[W] ? 1 : 15);
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
